cbus_arbiter: RTL and testbench

Shares the core's single memory bus between NUM_REQ requesters: index 0 is instruction fetch, index 1 is data memory. A small FSM grants one requester at a time and holds the grant until its burst completes. Beats are counted so each requester sees its last beat. Sits between the fetch/memory stages' bus ports and the external SRAM/AXI bridge.

---
 rtl/cbus_pkg.sv | 25 ++
 rtl/cbus_arb_pick.sv | 37 +++
 rtl/cbus_arbiter.sv | 131 +++++++++++++
 tb/tb_cbus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_pkg.sv
// Shared types for the core memory-bus arbiter: request/response bundles,
// arbiter state encoding and the fixed requester indices.
package cbus_pkg;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  // Widest burst-length field the request bundle can carry
  localparam int LEN_W_MAX = 16;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [31:0]          addr;
    logic [LEN_W_MAX-1:0] len;
    logic [3:0]           strobe;
    logic [31:0]          wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner picker. CBUS_ARB_ROUND_ROBIN_EN selects round-robin
// search from ptr+1; otherwise the highest valid index wins.
module cbus_arb_pick
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
)(
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [GW-1:0]      ptr,
  output logic               anyValid,
  output logic [GW-1:0]      winner
);
`ifdef CBUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    int idx;
    idx      = 0;
    anyValid = |reqValid;
    winner   = '0;
    // Walk from farthest to nearest so the slot right after ptr wins last
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (reqValid[idx]) winner = GW'(idx);
    end
  end
`else
  logic unusedPtr;
  assign unusedPtr = ^ptr;

  always_comb begin
    anyValid = |reqValid;
    winner   = '0;
    for (int i = REQ_FETCH; i < NUM_REQ; i++)
      if (reqValid[i]) winner = GW'(i);
  end
`endif
endmodule

// File: rtl/cbus_arbiter.sv
// Core memory-bus arbiter: one burst owner at a time, beat-counted completion.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4,
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*4-1:0]     req_strobe,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_last,
  output logic [31:0]              req_rdata,
  output logic                     mem_valid,
  output logic                     mem_write,
  output logic [31:0]              mem_addr,
  output logic [LEN_W-1:0]         mem_len,
  output logic [3:0]               mem_strobe,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_last,
  input  logic [31:0]              mem_rdata,
  output logic [GW-1:0]            grant_id,
  output logic                     proto_err
);
  if (NUM_REQ < REQ_DATA + 1 || NUM_REQ > 4 || LEN_W > LEN_W_MAX) begin : gBadCfg
    $error("cbus_arbiter: unsupported NUM_REQ/LEN_W");
  end

  cbus_req_t  reqs [NUM_REQ];
  cbus_req_t  cur;
  cbus_resp_t bus;
  arb_state_t state, stateNext;
  logic [LEN_W-1:0] cnt, lenQ;
  logic [GW-1:0]    grantId, ptrQ, winner;
  logic             anyValid, finalBeat, errNow, protoErr, unusedLenHi;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gReq
    assign reqs[g] = '{valid:    req_valid[g],
                       is_write: req_write[g],
                       addr:     req_addr[g*32 +: 32],
                       len:      LEN_W_MAX'(req_len[g*LEN_W +: LEN_W]),
                       strobe:   req_strobe[g*4 +: 4],
                       wdata:    req_wdata[g*32 +: 32]};
  end

  cbus_arb_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) uPick (
    .reqValid(req_valid),
    .ptr     (ptrQ),
    .anyValid(anyValid),
    .winner  (winner)
  );

  assign cur         = reqs[grantId];
  assign unusedLenHi = ^cur.len;
  assign finalBeat   = (state == BUSY) && mem_ready && (cnt == lenQ);
  // Counter decides completion; mem_last is only cross-checked against it
  assign errNow      = (state == BUSY) &&
                       ((mem_ready && mem_last && cnt != lenQ) ||
                        (mem_ready && cnt == lenQ && !mem_last) ||
                        !cur.valid);

  always_comb begin
    stateNext  = state;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_len    = '0;
    mem_strobe = '0;
    mem_wdata  = '0;
    bus        = '0;
    case (state)
      IDLE: if (anyValid) stateNext = BUSY;
      BUSY: begin
        mem_valid  = 1'b1;
        mem_write  = cur.is_write;
        mem_addr   = cur.addr;
        mem_len    = cur.len[LEN_W-1:0];
        mem_strobe = cur.strobe;
        mem_wdata  = cur.wdata;
        bus.ready  = mem_ready;
        bus.last   = finalBeat;
        bus.rdata  = mem_rdata;
        if (finalBeat) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign req_ready = {{(NUM_REQ-1){1'b0}}, bus.ready} << grantId;
  assign req_last  = {{(NUM_REQ-1){1'b0}}, bus.last}  << grantId;
  assign req_rdata = bus.rdata;
  assign grant_id  = grantId;
  assign proto_err = protoErr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lenQ     <= '0;
      grantId  <= '0;
      protoErr <= 1'b0;
    end else begin
      state    <= stateNext;
      protoErr <= protoErr | errNow;
      if (state == IDLE && anyValid) begin
        grantId <= winner;
        lenQ    <= reqs[winner].len[LEN_W-1:0];
        cnt     <= '0;
      end else if (state == BUSY && mem_ready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        ptrQ <= '0;
    else if (state == IDLE && anyValid) ptrQ <= winner;
  end
`else
  assign ptrQ = '0;
`endif
endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized scoreboard bench for cbus_arbiter: bursts are expanded into
// expected beats at issue time, a negedge monitor pops and compares them.
module tb_cbus_arbiter;
  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 4;
  localparam int GW      = 1;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0]            reqValid, reqWrite, reqReady, reqLast;
  logic [NUM_REQ-1:0][31:0]      reqAddr, reqWdata;
  logic [NUM_REQ-1:0][LEN_W-1:0] reqLen;
  logic [NUM_REQ-1:0][3:0]       reqStrobe;
  logic [31:0]      reqRdata, memAddr, memWdata, memRdata;
  logic             memValid, memWrite, memReady, memLast, protoErr;
  logic [LEN_W-1:0] memLen;
  logic [3:0]       memStrobe;
  logic [GW-1:0]    grantId;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr),
    .req_len(reqLen), .req_strobe(reqStrobe), .req_wdata(reqWdata),
    .req_ready(reqReady), .req_last(reqLast), .req_rdata(reqRdata),
    .mem_valid(memValid), .mem_write(memWrite), .mem_addr(memAddr),
    .mem_len(memLen), .mem_strobe(memStrobe), .mem_wdata(memWdata),
    .mem_ready(memReady), .mem_last(memLast), .mem_rdata(memRdata),
    .grant_id(grantId), .proto_err(protoErr)
  );

  typedef struct {
    int               id;
    int               beat;
    bit               last;
    logic [31:0]      addr;
    logic             write;
    logic [LEN_W-1:0] len;
    logic [3:0]       strobe;
    logic [31:0]      wdata;
  } beat_t;

  beat_t q[$];
  int checks = 0, errors = 0;
  bit monEn = 0, prevLast = 0;
  bit active [NUM_REQ];
  int beatCnt[NUM_REQ], dropAt[NUM_REQ];
  logic [31:0] wBase[NUM_REQ];
  int readyDelay = 0, rrPtr = 0;
  bit readyAlways = 0, earlyLast = 0;
  logic [NUM_REQ-1:0] readyS, lastS;
  logic mvS;
  logic [GW-1:0] gidS;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wdataOf(input int id, input int beat, input logic [31:0] base);
    return base ^ (32'(beat) * 32'h9E37_79B9) ^ 32'(id);
  endfunction

  // Monitor: every cycle the bus is owned, the owner's fields must match the head beat
  always @(negedge clk) if (monEn) begin
    beat_t e;
    if (prevLast) chk("idle_gap", 32'(memValid), 32'd0);
    prevLast = |reqLast;
    if (memValid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: mem_valid=1 with no expected burst at %0t", $time);
      end else begin
        e = q[0];
        chk("grant_id",   32'(grantId),   32'(e.id));
        chk("mem_addr",   memAddr,        e.addr);
        chk("mem_write",  32'(memWrite),  32'(e.write));
        chk("mem_len",    32'(memLen),    32'(e.len));
        chk("mem_strobe", 32'(memStrobe), 32'(e.strobe));
        chk("mem_wdata",  memWdata,       e.wdata);
        if (memReady) begin
          chk("req_ready", 32'(reqReady), 32'(1) << e.id);
          chk("req_last",  32'(reqLast),  32'(e.last) << e.id);
          chk("req_rdata", reqRdata,      memRdata);
          void'(q.pop_front());
        end else begin
          chk("ready_hold", 32'(reqReady), 32'd0);
        end
      end
    end else begin
      chk("idle_quiet", 32'({reqReady, reqLast}), 32'd0);
    end
  end

  // One cycle: sample at negedge, then requesters and memory react after the edge
  task automatic step();
    @(negedge clk);
    readyS = reqReady; lastS = reqLast; mvS = memValid; gidS = grantId;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active[i] && readyS[i]) begin
        beatCnt[i]++;
        if (lastS[i]) begin
          active[i] = 0; reqValid[i] = 1'b0;
        end else begin
          reqWdata[i] = wdataOf(i, beatCnt[i], wBase[i]);
          if (beatCnt[i] == dropAt[i]) reqValid[i] = 1'b0;
        end
      end
    end
    memRdata = $urandom;
    memReady = 1'b0;
    memLast  = 1'b0;
    if (memValid && q.size() > 0) begin
      if (readyDelay > 0) readyDelay--;
      else memReady = readyAlways || ($urandom_range(2) != 0);
      memLast = earlyLast ? (q[0].beat == 1) : q[0].last;
    end
  endtask

  task automatic setReq(input int i, input bit wr, input logic [31:0] addr,
                        input int len, input logic [3:0] strobe);
    reqWrite[i]  = wr;
    reqAddr[i]   = addr;
    reqLen[i]    = LEN_W'(len);
    reqStrobe[i] = strobe;
    wBase[i]     = $urandom;
  endtask

  // All requesters in mask raise valid together from IDLE; model expands the grant order
  task automatic runEp(input logic [NUM_REQ-1:0] mask);
    int order[$];
    int first, k;
    `ifdef CBUS_ARB_ROUND_ROBIN_EN
    for (int s = 1; s <= NUM_REQ; s++)
      if (mask[(rrPtr + s) % NUM_REQ]) order.push_back((rrPtr + s) % NUM_REQ);
    rrPtr = order[order.size()-1];
    `else
    for (int j = NUM_REQ-1; j >= 0; j--) if (mask[j]) order.push_back(j);
    `endif
    foreach (order[n]) begin
      int j;
      j = order[n];
      for (int b = 0; b <= int'(reqLen[j]); b++)
        q.push_back('{j, b, b == int'(reqLen[j]), reqAddr[j], reqWrite[j],
                      reqLen[j], reqStrobe[j], wdataOf(j, b, wBase[j])});
    end
    for (int i = 0; i < NUM_REQ; i++) if (mask[i]) begin
      active[i] = 1; beatCnt[i] = 0; reqValid[i] = 1'b1;
      reqWdata[i] = wdataOf(i, 0, wBase[i]);
    end
    first = order[0];
    k = 0;
    while (q.size() > 0 || active.or() != 0) begin
      step();
      if (k == 0) chk("grant_wait", 32'(mvS), 32'd0);
      if (k == 1) begin
        chk("grant_lat", 32'(mvS), 32'd1);
        chk("first_grant", 32'(gidS), 32'(first));
      end
      k++;
      if (k > 400) begin
        checks++; errors++;
        $display("FAIL ep_timeout: %0d beats still pending", q.size());
        q.delete();
        foreach (active[i]) begin active[i] = 0; reqValid[i] = 1'b0; end
        break;
      end
    end
  endtask

  initial begin
    reqValid = '0; reqWrite = '0; reqAddr = '0; reqLen = '0; reqStrobe = '0; reqWdata = '0;
    memReady = 0; memLast = 0; memRdata = '0;
    foreach (dropAt[i]) begin dropAt[i] = -1; active[i] = 0; beatCnt[i] = 0; end
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_valid", 32'(memValid), 32'd0);
    chk("rst_req_ready", 32'({reqReady, reqLast}), 32'd0);
    chk("rst_grant_id",  32'(grantId),  32'd0);
    chk("rst_proto_err", 32'(protoErr), 32'd0);
    chk("rst_rdata",     reqRdata,      32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    monEn = 1;
    step();

    // Random bursts, all protocol-clean
    repeat (30) begin
      for (int i = 0; i < NUM_REQ; i++)
        setReq(i, 1'($urandom), $urandom, $urandom_range(0, 7), 4'($urandom));
      readyAlways = 1'($urandom);
      runEp(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
      chk("proto_clean", 32'(protoErr), 32'd0);
    end

    // Single read from the boot vector, ready every cycle
    readyAlways = 1;
    setReq(0, 0, 32'hBFC0_0000, 3, 4'hF);
    runEp(2'b01);
    // Contention twice: fixed gives 1 then 0 each time; RR alternates too
    setReq(0, 0, 32'h0000_1000, 1, 4'hF);
    setReq(1, 1, 32'h0000_2000, 2, 4'hF);
    runEp(2'b11);
    runEp(2'b11);
    // Single-beat write held off by a slow bus
    setReq(1, 1, 32'h8000_0040, 0, 4'b0011);
    readyDelay = 3;
    runEp(2'b10);
    chk("proto_clean_dir", 32'(protoErr), 32'd0);

    // mem_last arrives on the second beat of a four-beat burst
    earlyLast = 1;
    setReq(0, 0, 32'h0000_3000, 3, 4'hF);
    runEp(2'b01);
    earlyLast = 0;
    chk("proto_early_last", 32'(protoErr), 32'd1);
    setReq(1, 0, 32'h0000_4000, 1, 4'hF);
    runEp(2'b10);
    chk("proto_sticky", 32'(protoErr), 32'd1);

    // Reset mid-burst, with a beat being offered at that moment
    setReq(0, 0, 32'h0000_5000, 3, 4'hF);
    fork
      runEp(2'b01);
    join_none
    for (int w = 0; w < 50 && beatCnt[0] < 2; w++) @(posedge clk);
    #1;
    disable fork;
    memReady = 1'b1;
    #2;
    monEn = 0;
    reset = 1'b1;
    #1;
    chk("arst_mem_valid", 32'(memValid), 32'd0);
    chk("arst_req_ready", 32'(reqReady), 32'd0);
    chk("arst_req_last",  32'(reqLast),  32'd0);
    chk("arst_grant_id",  32'(grantId),  32'd0);
    chk("arst_proto_err", 32'(protoErr), 32'd0);
    q.delete();
    foreach (active[i]) begin active[i] = 0; reqValid[i] = 1'b0; end
    memReady = 1'b0; memLast = 1'b0; rrPtr = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(memValid), 32'd0);
    prevLast = 0;
    monEn = 1;
    step();

    // Requester abandons its burst after the first beat
    setReq(1, 0, 32'h0000_6000, 3, 4'hF);
    dropAt[1] = 1;
    runEp(2'b10);
    dropAt[1] = -1;
    chk("proto_valid_drop", 32'(protoErr), 32'd1);

    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    monEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
